// File: rtl/keypad_pkg.sv
// Shared key codes, scanner state encoding and helpers
// for the keypad code entry front end.
package keypad_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hE;
  localparam logic [3:0] KEY_ENTER = 4'hF;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } scan_state_t;

  // Lowest-numbered active-low line wins.
  function automatic logic [1:0] low_idx(
    input logic [3:0] v
  );
    if (!v[0])      return 2'd0;
    else if (!v[1]) return 2'd1;
    else if (!v[2]) return 2'd2;
    else            return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Matrix scanner: row sync, column rotation,
// press debounce and release tracking.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_event,
  output logic [3:0] key_value
);

  localparam int DW = $clog2(SCAN_DIV + 1);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] SETTLE   = DW'(2);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    row_s1;
  logic [3:0]    row_s2;
  scan_state_t   state;
  logic [DW-1:0] div;
  logic [CW-1:0] deb;
  logic [3:0]    pattern;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      col       <= 4'b1110;
      div       <= '0;
      deb       <= '0;
      pattern   <= 4'hF;
      key_event <= 1'b0;
      key_value <= 4'h0;
    end else begin
      key_event <= 1'b0;
      unique case (state)
        SCAN: begin
          // Rows lag the column by two sync stages; only trust
          // them once the current column has settled through.
          if (div >= SETTLE && row_s2 != 4'hF) begin
            state     <= DEBOUNCE;
            pattern   <= row_s2;
            key_value <= {low_idx(row_s2), low_idx(col)};
            deb       <= CW'(1);
            div       <= '0;
          end else if (div == DIV_LAST) begin
            div <= '0;
            col <= {col[2:0], col[3]};
          end else begin
            div <= div + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (row_s2 != pattern) begin
            state <= SCAN;
            div   <= '0;
          end else if (deb == DEB_LAST) begin
            state     <= HELD;
            key_event <= 1'b1;
            deb       <= '0;
          end else begin
            deb <= deb + 1'b1;
          end
        end
        HELD: begin
          if (row_s2 != 4'hF) begin
            deb <= '0;
          end else if (deb == DEB_LAST) begin
            state <= SCAN;
            div   <= '0;
            deb   <= '0;
          end else begin
            deb <= deb + 1'b1;
          end
        end
        default: begin
          state <= SCAN;
          div   <= '0;
          deb   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/keypad_code_entry.sv
// Keypad code entry: digit buffer, ENTER/CLEAR handling,
// idle timeout and lockout gating on top of the scanner.
module keypad_code_entry
  import keypad_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [3:0]                        row,
  output logic [3:0]                        col,
  input  logic                              lockout,
  output logic [4*NUM_DIGITS-1:0]           code,
  output logic                              code_valid,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
  output logic                              key_error,
  output logic                              entry_busy
);

  localparam int CODE_W = 4 * NUM_DIGITS;
  localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(NUM_DIGITS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic              key_event;
  logic [3:0]        key_value;
  logic [CODE_W-1:0] buffer;
  logic [TMO_W-1:0]  tmo;

  keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_scanner (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_event (key_event),
    .key_value (key_value)
  );

  assign entry_busy = (digit_count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buffer      <= '0;
      digit_count <= '0;
      code        <= '0;
      code_valid  <= 1'b0;
      key_error   <= 1'b0;
      tmo         <= '0;
    end else begin
      code_valid <= 1'b0;
      key_error  <= 1'b0;
      if (lockout) begin
        buffer      <= '0;
        digit_count <= '0;
        tmo         <= '0;
      end else if (key_event) begin
        tmo <= '0;
        unique case (1'b1)
          (key_value == KEY_CLEAR): begin
            buffer      <= '0;
            digit_count <= '0;
          end
          (key_value == KEY_ENTER): begin
            if (digit_count == FULL) begin
              code       <= buffer;
              code_valid <= 1'b1;
            end else begin
              key_error <= 1'b1;
            end
            buffer      <= '0;
            digit_count <= '0;
          end
          default: begin
            if (digit_count == FULL) begin
              key_error <= 1'b1;
            end else begin
              buffer      <= (buffer << 4) | CODE_W'(key_value);
              digit_count <= digit_count + 1'b1;
            end
          end
        endcase
      end else if (digit_count != '0) begin
        if (tmo == TMO_LAST) begin
          buffer      <= '0;
          digit_count <= '0;
          tmo         <= '0;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end else begin
        tmo <= '0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_code_entry.sv
// Scoreboard bench: stimulus queues expected valid/error
// pulses, a monitor pops them as the DUT strobes.
module tb_keypad_code_entry;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        lockout;
  logic [15:0] code;
  logic        code_valid;
  logic [2:0]  digit_count;
  logic        key_error;
  logic        entry_busy;

  logic        pressed;
  logic [3:0]  key;

  typedef struct packed {
    logic        is_valid;
    logic [15:0] code;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  keypad_code_entry dut (
    .clk         (clk),
    .reset       (reset),
    .row         (row),
    .col         (col),
    .lockout     (lockout),
    .code        (code),
    .code_valid  (code_valid),
    .digit_count (digit_count),
    .key_error   (key_error),
    .entry_busy  (entry_busy)
  );

  always #5 clk = ~clk;

  // Keypad model: pressed key pulls its row low while its column is driven.
  always_comb begin
    row = 4'hF;
    if (pressed && col[key[1:0]] == 1'b0)
      row[key[3:2]] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && (code_valid || key_error)) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: valid=%0b err=%0b code=%0h",
                 code_valid, key_error, code);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("strobe_kind", {code_valid, key_error},
            {e.is_valid, ~e.is_valid});
        chk("strobe_code", 32'(code), 32'(e.code));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] k);
    key     = k;
    pressed = 1'b1;
    idle(60);
    pressed = 1'b0;
    idle(40);
  endtask

  task automatic chk_count(input string name, input int exp);
    chk(name, 32'(digit_count), 32'(exp));
    chk({name, "_busy"}, 32'(entry_busy), 32'(exp != 0));
  endtask

  initial begin
    reset   = 1'b0;
    lockout = 1'b0;
    pressed = 1'b0;
    key     = 4'h0;
    idle(3);
    chk("rst_col", 32'(col), 32'hE);
    chk("rst_code", 32'(code), 32'h0);
    chk("rst_strobes", {code_valid, key_error}, 32'h0);
    chk_count("rst_count", 0);
    reset = 1'b1;
    idle(5);

    // 1,2,3,A then ENTER
    press(4'd1);  chk_count("cnt_1", 1);
    press(4'd2);  chk_count("cnt_2", 2);
    press(4'd3);  chk_count("cnt_3", 3);
    press(4'd10); chk_count("cnt_4", 4);
    q.push_back('{is_valid: 1'b1, code: 16'h123A});
    press(4'hF);
    chk_count("enter_cnt", 0);
    chk("enter_code", 32'(code), 32'h123A);

    // Bouncing press of 9 yields one digit
    key = 4'd9;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) pressed = ~pressed;
      @(negedge clk);
    end
    press(4'd9);
    chk_count("bounce_cnt", 1);
    press(4'hE);
    chk_count("clear_after_bounce", 0);

    // Short ENTER
    press(4'd5);
    press(4'd6);
    chk_count("short_cnt", 2);
    q.push_back('{is_valid: 1'b0, code: 16'h123A});
    press(4'hF);
    chk_count("short_enter_cnt", 0);
    chk("short_enter_code", 32'(code), 32'h123A);

    // Overflow then CLEAR
    press(4'd0);
    press(4'd11);
    press(4'd12);
    press(4'd13);
    q.push_back('{is_valid: 1'b0, code: 16'h123A});
    press(4'd7);
    chk_count("overflow_cnt", 4);
    press(4'hE);
    chk_count("clear_cnt", 0);

    // Full entry with a zero leading digit
    press(4'd0);
    press(4'd11);
    press(4'd12);
    press(4'd13);
    q.push_back('{is_valid: 1'b1, code: 16'h0BCD});
    press(4'hF);
    chk("code_0bcd", 32'(code), 32'h0BCD);

    // Timeout
    press(4'd7);
    chk_count("tmo_before", 1);
    idle(1100);
    chk_count("tmo_after", 0);

    // Lockout blocks entry
    lockout = 1'b1;
    press(4'd1);
    press(4'd2);
    press(4'd3);
    press(4'd4);
    chk_count("lock_cnt", 0);
    press(4'hF);
    lockout = 1'b0;
    idle(2);
    chk_count("lock_after", 0);
    chk("lock_code", 32'(code), 32'h0BCD);

    // Reset while a key is held
    key     = 4'd8;
    pressed = 1'b1;
    idle(50);
    #1 reset = 1'b0;
    #1;
    chk("midheld_col", 32'(col), 32'hE);
    chk("midheld_code", 32'(code), 32'h0);
    chk("midheld_strobes", {code_valid, key_error}, 32'h0);
    chk_count("midheld_cnt", 0);
    pressed = 1'b0;
    idle(3);
    reset = 1'b1;
    idle(5);

    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
